// File: rtl/tt_wb_mux_ctrl_if.sv
// rtl/tt_wb_mux_ctrl_if.sv - Wishbone slave bus bundle for the mux controller
interface tt_wb_mux_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/tt_wb_mux_ctrl.sv
// rtl/tt_wb_mux_ctrl.sv - Wishbone register block sequencing a design-select mux chain
module tt_wb_mux_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SEL_W     = 10
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    tt_wb_mux_ctrl_if.slave  wb,
    output logic             ctrl_ena,
    output logic             ctrl_sel_rst_n,
    output logic             ctrl_sel_inc
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST_LO = 3'd1,
        RST_HI = 3'd2,
        INC_HI = 3'd3,
        INC_LO = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         timer_q, timer_d;
    logic [SEL_W-1:0]   ctr_q, ctr_d;
    logic [SEL_W-1:0]   ctr_inc;
    logic               seg_end;

    logic               ack_q;
    logic               hit;
    logic [1:0]         idx;
    logic               wr_en;
    logic               start_req;
    logic [31:0]        lane_mask;
    logic [31:0]        rd_data;

    logic               ena_q;
    logic [SEL_W-1:0]   target_q;
    logic [7:0]         width_q;
    logic [SEL_W-1:0]   current_q;
    logic [7:0]         dur_q;
    logic [SEL_W-1:0]   n_q;
    logic               busy;

    assign hit   = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign idx   = wb.wbs_adr_i[3:2];
    // Writes commit in the ack cycle, while the master still holds the request.
    assign wr_en = ack_q & hit & wb.wbs_we_i;
    assign start_req = wr_en & (idx == 2'd0) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
    assign lane_mask = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                        {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
    assign busy = (state_q != IDLE);

    logic unused_bits;
    assign unused_bits = &{1'b0, wb.wbs_adr_i[1:0], lane_mask[31:SEL_W], wb.wbs_dat_i[31:SEL_W]};

    // Single-cycle ack; the ~ack_q term forces an idle cycle between acks.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= hit & ~ack_q;
        end
    end

    // Software-visible control registers with per-byte-lane writes.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ena_q    <= 1'b0;
            target_q <= '0;
            width_q  <= 8'd2;
        end else if (wr_en) begin
            case (idx)
                2'd0: if (wb.wbs_sel_i[0]) ena_q <= wb.wbs_dat_i[0];
                2'd1: target_q <= (target_q & ~lane_mask[SEL_W-1:0]) |
                                  (wb.wbs_dat_i[SEL_W-1:0] & lane_mask[SEL_W-1:0]);
                2'd3: if (wb.wbs_sel_i[0]) width_q <= wb.wbs_dat_i[7:0];
                default: ;
            endcase
        end
    end

    // Sequence parameters are snapshotted at START so register writes mid-run do not disturb it.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dur_q     <= 8'd1;
            n_q       <= '0;
            current_q <= '0;
        end else begin
            if ((state_q == IDLE) && start_req) begin
                dur_q <= (width_q == 8'd0) ? 8'd1 : width_q;
                n_q   <= target_q;
            end
            if (state_q == DONE) begin
                current_q <= n_q;
            end
        end
    end

    // Sequencer state, segment timer and pulse counter.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ctr_q   <= ctr_d;
        end
    end

    // Next-state logic: each timed state lasts dur_q cycles, DONE lasts one.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ctr_d   = ctr_q;
        ctr_inc = ctr_q + SEL_W'(1);
        seg_end = (timer_q == (dur_q - 8'd1));
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = RST_LO;
                    timer_d = '0;
                    ctr_d   = '0;
                end
            end
            RST_LO: begin
                timer_d = timer_q + 8'd1;
                if (seg_end) begin
                    state_d = RST_HI;
                    timer_d = '0;
                end
            end
            RST_HI: begin
                timer_d = timer_q + 8'd1;
                if (seg_end) begin
                    state_d = (n_q != '0) ? INC_HI : DONE;
                    timer_d = '0;
                end
            end
            INC_HI: begin
                timer_d = timer_q + 8'd1;
                if (seg_end) begin
                    state_d = INC_LO;
                    timer_d = '0;
                end
            end
            INC_LO: begin
                timer_d = timer_q + 8'd1;
                if (seg_end) begin
                    ctr_d   = ctr_inc;
                    state_d = (ctr_inc < n_q) ? INC_HI : DONE;
                    timer_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register read mux; unimplemented bits read as zero.
    always_comb begin
        rd_data = '0;
        case (idx)
            2'd0: rd_data[0] = ena_q;
            2'd1: rd_data[SEL_W-1:0] = target_q;
            2'd2: begin
                rd_data[0]           = busy;
                rd_data[SEL_W+15:16] = current_q;
            end
            2'd3: rd_data[7:0] = width_q;
            default: ;
        endcase
    end

    assign wb.wbs_ack_o   = ack_q;
    assign wb.wbs_dat_o   = ack_q ? rd_data : '0;
    assign ctrl_ena       = (state_q == IDLE) & ena_q;
    assign ctrl_sel_rst_n = (state_q != RST_LO);
    assign ctrl_sel_inc   = (state_q == INC_HI);

endmodule

// File: tb/tb_tt_wb_mux_ctrl.sv
// tb/tb_tt_wb_mux_ctrl.sv - directed self-checking bench for tt_wb_mux_ctrl
module tb_tt_wb_mux_ctrl;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_TGT  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_WID  = BASE + 32'hC;
    localparam int          NOACK  = 99;

    logic clk = 1'b0;
    logic rst_n;
    logic ctrl_ena, ctrl_sel_rst_n, ctrl_sel_inc;

    always #5 clk = ~clk;

    tt_wb_mux_ctrl_if bus();

    tt_wb_mux_ctrl #(.BASE_ADDR(BASE), .SEL_W(10)) dut (
        .wb_clk_i       (clk),
        .rst_n          (rst_n),
        .wb             (bus),
        .ctrl_ena       (ctrl_ena),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observes the mux-chain outputs on falling edges while mon_en is set.
    logic mon_en = 1'b0;
    logic inc_prev;
    int   rst_lo_cnt, inc_hi_cnt, pulses, ena_lo_cnt, cyc_n, first_rst, last_inc;

    always @(negedge clk) begin
        if (!mon_en) begin
            rst_lo_cnt = 0; inc_hi_cnt = 0; pulses = 0; ena_lo_cnt = 0;
            cyc_n = 0; first_rst = -1; last_inc = 0; inc_prev = 1'b0;
        end else begin
            cyc_n++;
            if (!ctrl_sel_rst_n) begin
                rst_lo_cnt++;
                if (first_rst < 0) first_rst = cyc_n;
            end
            if (ctrl_sel_inc) begin
                inc_hi_cnt++;
                last_inc = cyc_n;
                if (!inc_prev) pulses++;
            end
            inc_prev = ctrl_sel_inc;
            if (!ctrl_ena) ena_lo_cnt++;
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata,
                           output int lat, output logic ack_after);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        lat       = NOACK;
        rdata     = '0;
        ack_after = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin
                lat   = i;
                rdata = bus.wbs_dat_o;
                break;
            end
        end
        if (lat != NOACK) begin
            @(posedge clk); #1;
            ack_after = bus.wbs_ack_o;
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        aa;

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        int          l;
        logic        a;
        wb_xfer(1'b1, adr, dat, 4'hF, r, l, a);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        int          l;
        logic        a;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, r, l, a);
        check(tag, r, exp);
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = '0;   bus.wbs_adr_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_ena", {31'd0, ctrl_ena}, 32'd0);
        check("rst_selrst", {31'd0, ctrl_sel_rst_n}, 32'd1);
        check("rst_inc", {31'd0, ctrl_sel_inc}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset register values and single-cycle ack timing.
        wb_xfer(1'b0, A_WID, 32'h0, 4'hF, rd, lat, aa);
        check("width_rst", rd, 32'h2);
        check("ack_latency", lat, 32'd1);
        check("ack_single", {31'd0, aa}, 32'd0);
        rd_chk("ctrl_rst", A_CTRL, 32'h0);
        rd_chk("target_rst", A_TGT, 32'h0);
        rd_chk("status_rst", A_STAT, 32'h0);

        // Byte-lane write and out-of-window access.
        wb_xfer(1'b1, A_TGT, 32'h3FF, 4'b0001, rd, lat, aa);
        rd_chk("target_lane0", A_TGT, 32'h0FF);
        wb_xfer(1'b1, BASE + 32'h14, 32'h155, 4'hF, rd, lat, aa);
        check("noack_0x14", lat, NOACK);
        wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, aa);
        check("noack_0x10", lat, NOACK);
        rd_chk("target_kept", A_TGT, 32'h0FF);

        // Unimplemented bits read as zero.
        wr(A_WID, 32'hFFFF_FF05);
        rd_chk("width_mask", A_WID, 32'h05);
        wr(A_TGT, 32'hFFFF_FFFF);
        rd_chk("target_mask", A_TGT, 32'h3FF);

        // W=1, N=3: one-cycle reset low, three 1-high/1-low pulses, 9 busy cycles.
        wr(A_WID, 32'h1);
        wr(A_TGT, 32'h3);
        mon_en = 1'b1;
        wr(A_CTRL, 32'h2);
        repeat (20) @(posedge clk);
        #1;
        check("s1_rst_lo", rst_lo_cnt, 32'd1);
        check("s1_pulses", pulses, 32'd3);
        check("s1_inc_hi", inc_hi_cnt, 32'd3);
        check("s1_span", last_inc - first_rst + 1, 32'd7);
        mon_en = 1'b0;
        rd_chk("s1_status", A_STAT, 32'h0003_0000);
        rd_chk("s1_ctrl", A_CTRL, 32'h0);

        // ENA passthrough, then START with N=0 and W=2: ena low for 5 cycles.
        wr(A_TGT, 32'h0);
        wr(A_WID, 32'h2);
        wr(A_CTRL, 32'h1);
        check("ena_idle", {31'd0, ctrl_ena}, 32'd1);
        mon_en = 1'b1;
        wr(A_CTRL, 32'h3);
        repeat (20) @(posedge clk);
        #1;
        check("s2_ena_lo", ena_lo_cnt, 32'd5);
        check("s2_pulses", pulses, 32'd0);
        check("s2_rst_lo", rst_lo_cnt, 32'd2);
        check("s2_ena_back", {31'd0, ctrl_ena}, 32'd1);
        mon_en = 1'b0;
        rd_chk("s2_status", A_STAT, 32'h0);

        // START and TARGET writes while busy do not affect the running W=2, N=2 sequence.
        wr(A_TGT, 32'h2);
        mon_en = 1'b1;
        wr(A_CTRL, 32'h3);
        wr(A_CTRL, 32'h3);
        wr(A_TGT, 32'h5);
        wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, rd, lat, aa);
        check("s3_busy", rd & 32'h1, 32'h1);
        repeat (30) @(posedge clk);
        #1;
        check("s3_ena_lo", ena_lo_cnt, 32'd13);
        check("s3_pulses", pulses, 32'd2);
        check("s3_inc_hi", inc_hi_cnt, 32'd4);
        mon_en = 1'b0;
        rd_chk("s3_status", A_STAT, 32'h0002_0000);
        rd_chk("s3_target", A_TGT, 32'h5);

        // Reset asserted while the increment strobe is high.
        wr(A_TGT, 32'h3);
        wr(A_CTRL, 32'h2);
        for (int i = 0; i < 40; i++) begin
            if (ctrl_sel_inc) break;
            @(posedge clk); #1;
        end
        check("s4_inc_seen", {31'd0, ctrl_sel_inc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s4_inc", {31'd0, ctrl_sel_inc}, 32'd0);
        check("s4_selrst", {31'd0, ctrl_sel_rst_n}, 32'd1);
        check("s4_ena", {31'd0, ctrl_ena}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("s4_status", A_STAT, 32'h0);
        rd_chk("s4_width", A_WID, 32'h2);
        rd_chk("s4_target", A_TGT, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_wb_mux_ctrl.md
TT_WB_MUX_CTRL -- requirements
Module: tt_wb_mux_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; register window is BASE_ADDR..BASE_ADDR+0xF.
REQ-002 SHALL have parameter SEL_W, default 10, width of the design-select address.
REQ-003 SHALL have port wb_clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port wbs_stb_i, input, 1, Wishbone strobe.
REQ-006 SHALL have port wbs_cyc_i, input, 1, Wishbone cycle.
REQ-007 SHALL have port wbs_we_i, input, 1, write enable.
REQ-008 SHALL have port wbs_sel_i, input, 4, byte-lane select.
REQ-009 SHALL have port wbs_dat_i, input, 32, write data.
REQ-010 SHALL have port wbs_adr_i, input, 32, byte address.
REQ-011 SHALL have port wbs_ack_o, output, 1, Wishbone acknowledge.
REQ-012 SHALL have port wbs_dat_o, output, 32, read data.
REQ-013 SHALL have port ctrl_ena, output, 1, enable to the selected design.
REQ-014 SHALL have port ctrl_sel_rst_n, output, 1, active-low reset of the mux select chain.
REQ-015 SHALL have port ctrl_sel_inc, output, 1, select-increment strobe to the mux chain.

Function
REQ-016 SHALL decode a hit when wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]); the register index is wbs_adr_i[3:2].
REQ-017 SHALL implement these registers:
- 0x0 CTRL: bit0 ENA (RW); bit1 START (write-1 pulse, reads 0).
- 0x4 TARGET: [SEL_W-1:0] (RW).
- 0x8 STATUS: bit0 BUSY; [SEL_W+15:16] CURRENT (RO).
- 0xC WIDTH: [7:0] (RW).
REQ-018 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after a hit is sampled with ack low, and SHALL hold ack low for at least one cycle between acks (no back-to-back ack).
REQ-019 SHALL perform writes in the ack cycle, honouring wbs_sel_i per byte lane; read data SHALL be valid while ack is high and 0 otherwise.
REQ-020 SHALL ack non-hits never; reads of unimplemented bits SHALL return 0.
REQ-021 SHALL run a sequence FSM with states IDLE, RST_LO, RST_HI, INC_HI, INC_LO, DONE.
REQ-022 SHALL latch W = max(WIDTH,1) and N = TARGET on the START write while in IDLE, then enter RST_LO.
REQ-023 SHALL use these state durations and transitions:
- RST_LO: ctrl_sel_rst_n=0 for W cycles -> RST_HI.
- RST_HI: rst_n high for W cycles -> INC_HI if N>0, else DONE.
- INC_HI: ctrl_sel_inc=1 for W cycles -> INC_LO.
- INC_LO: inc=0 for W cycles, counter+1 -> INC_HI if counter<N, else DONE.
- DONE: 1 cycle -> IDLE; CURRENT=N.
REQ-024 SHALL force ctrl_ena=0 whenever the FSM is not IDLE; in IDLE ctrl_ena=CTRL.ENA.
REQ-025 SHALL report BUSY=1 in every state except IDLE.
REQ-026 SHALL ignore START while BUSY; writes to TARGET and WIDTH while BUSY SHALL update the register but not the running sequence.
REQ-027 SHALL make the sequence length deterministic: total busy cycles = 2W + 2W*N + 1.
REQ-028 SHALL handle N = 2^SEL_W-1 without counter wrap; the counter width SHALL be SEL_W.

Reset
REQ-029 SHALL on rst_n low asynchronously drive: wbs_ack_o=0, wbs_dat_o=0, ctrl_ena=0, ctrl_sel_rst_n=1, ctrl_sel_inc=0, FSM=IDLE, ENA=0, TARGET=0, WIDTH=8'd2, CURRENT=0.
REQ-030 SHALL abort a sequence in progress on reset mid-operation, with outputs taking their reset values immediately; CURRENT SHALL be 0 after reset.

Verification
REQ-031 SHALL cover: write 0xC=1, 0x4=3, 0x0=2 -> rst_n low for 1 cycle, then 3 inc pulses each 1 cycle high / 1 low; STATUS reads 0x0003_0000 after 9 cycles busy.
REQ-032 SHALL cover: read 0xC after reset -> 0x0000_0002 with a single-cycle ack one cycle after stb.
REQ-033 SHALL cover: write 0x0=1 in IDLE -> ctrl_ena=1; then START with TARGET=0 -> ctrl_ena=0 for 5 cycles (W=2), no inc pulses, ctrl_ena returns to 1.
REQ-034 SHALL cover: START issued while BUSY -> no restart, and the pulse count equals the original N.
REQ-035 SHALL cover: rst_n asserted during INC_HI -> ctrl_sel_inc=0 and ctrl_sel_rst_n=1 in the same cycle, and STATUS=0.
REQ-036 SHALL cover: byte-lane write 0x4 with wbs_sel_i=4'b0001, data 0x3FF -> TARGET=0x0FF; an access at BASE_ADDR+0x10 -> no ack.
